cannon_sequencer: RTL and testbench

- Upstream command sequencer for the N×N `message_passer` PE array.
- Issues one global command at a time to every PE and waits for all PE `ready` bits, using the `ack`-gated issue/complete handshake.
- Sequence is a full Cannon-style matrix-multiply pass: reset, load, then N rounds of multiply and shift.
- Host supplies pre-skewed A/B operands on the PEs' overwrite buses, pulses `go`, and reads `done`/`error`.

---
 rtl/cannon_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_cannon_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cannon_sequencer.sv
// cannon_sequencer
//   Drives one global command at a time into an N x N message_passer PE
//   array and walks it through a full Cannon matrix-multiply pass:
//   reset, load, then N rounds of multiply / shift_left(A) / shift_up(B)
//   (the shifts are skipped after the final multiply), 3N steps in total.
//
// Ports
//   CLK                 rising-edge clock
//   reset_n             synchronous active-low reset
//   go                  start a pass (accepted only while idle)
//   abort               drop back to idle on the next edge, highest priority
//                       after reset
//   pe_ready[N*N]       concatenated PE ready bits
//   command_to_execute  global PE command (last issued value while ack=1)
//   image_to_shift      0 = A, 1 = B
//   start               high during the single issue cycle of a step
//   ack                 low during the issue cycle only
//   busy                high while issuing or waiting
//   done / error        sticky completion / timeout flags, cleared by go
//   round               current multiply round 0..N-1
//
// Handshake: a step is issued by holding ack low for exactly one cycle; the
// PEs execute on that edge and raise ready. The step completes in the first
// WAIT cycle that sees all ready bits high; ack is high in that cycle, which
// clears the PE ready bits on the same edge that moves us to the next issue.
// Ready bits are ignored outside WAIT.
module cannon_sequencer #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic                 abort,
  input  logic [N*N-1:0]       pe_ready,
  output logic [2:0]           command_to_execute,
  output logic                 image_to_shift,
  output logic                 start,
  output logic                 ack,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [$clog2(N):0]   round
);

  localparam int RW = $clog2(N) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] CMD_MUL   = 3'b000;
  localparam logic [2:0] CMD_SHU   = 3'b001;
  localparam logic [2:0] CMD_SHL   = 3'b011;
  localparam logic [2:0] CMD_LOAD  = 3'b101;
  localparam logic [2:0] CMD_RESET = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [2:0] {P_RESET, P_LOAD, P_MUL, P_SHL, P_SHU} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [RW-1:0]   round_q, round_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            img_q, img_d;

  logic            enter_issue;
  phase_t          issue_phase;

  function automatic logic [2:0] cmd_of(input phase_t p);
    case (p)
      P_RESET: cmd_of = CMD_RESET;
      P_LOAD:  cmd_of = CMD_LOAD;
      P_MUL:   cmd_of = CMD_MUL;
      P_SHL:   cmd_of = CMD_SHL;
      P_SHU:   cmd_of = CMD_SHU;
      default: cmd_of = CMD_RESET;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      phase_q <= P_RESET;
      round_q <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cmd_q   <= CMD_RESET;
      img_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      round_q <= round_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
      error_q <= error_d;
      cmd_q   <= cmd_d;
      img_q   <= img_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    round_d     = round_q;
    tcnt_d      = tcnt_q;
    done_d      = done_q;
    error_d     = error_q;
    cmd_d       = cmd_q;
    img_d       = img_q;
    enter_issue = 1'b0;
    issue_phase = phase_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            done_d      = 1'b0;
            error_d     = 1'b0;
            round_d     = '0;
            enter_issue = 1'b1;
            issue_phase = P_RESET;
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
          tcnt_d  = '0;
        end
        S_WAIT: begin
          if (&pe_ready) begin
            case (phase_q)
              P_RESET: begin enter_issue = 1'b1; issue_phase = P_LOAD; end
              P_LOAD:  begin enter_issue = 1'b1; issue_phase = P_MUL;  end
              P_MUL: begin
                // The last round has no shifts: the pass ends here.
                if (round_q == RW'(N - 1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end else begin
                  enter_issue = 1'b1;
                  issue_phase = P_SHL;
                end
              end
              P_SHL:   begin enter_issue = 1'b1; issue_phase = P_SHU;  end
              P_SHU: begin
                round_d     = round_q + RW'(1);
                enter_issue = 1'b1;
                issue_phase = P_MUL;
              end
              default: state_d = S_IDLE;
            endcase
          end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Command/image registers only change when a new step is issued, so they
    // hold the last issued values while ack is high.
    if (enter_issue) begin
      state_d = S_ISSUE;
      phase_d = issue_phase;
      cmd_d   = cmd_of(issue_phase);
      img_d   = (issue_phase == P_SHU);
    end
  end

  assign start              = (state_q == S_ISSUE);
  assign ack                = ~start;
  assign busy               = (state_q != S_IDLE);
  assign done               = done_q;
  assign error              = error_q;
  assign round              = round_q;
  assign command_to_execute = cmd_q;
  assign image_to_shift     = img_q;

endmodule

// File: tb/tb_cannon_sequencer.sv
// Bench for cannon_sequencer (N=2, TIMEOUT=16): directed scenarios with
// literal expectations plus a randomized phase, all continuously compared
// against a step-list reference model.
module tb_cannon_sequencer;

  localparam int N       = 2;
  localparam int TIMEOUT = 16;
  localparam int NN      = N * N;
  localparam int NSTEP   = 3 * N;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          go;
  logic          abort;
  logic [NN-1:0] pe_ready;
  logic [2:0]    command_to_execute;
  logic          image_to_shift;
  logic          start;
  logic          ack;
  logic          busy;
  logic          done;
  logic          error;
  logic [$clog2(N):0] round;

  cannon_sequencer #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .CLK                (clk),
    .reset_n            (reset_n),
    .go                 (go),
    .abort              (abort),
    .pe_ready           (pe_ready),
    .command_to_execute (command_to_execute),
    .image_to_shift     (image_to_shift),
    .start              (start),
    .ack                (ack),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .round              (round)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The pass is a fixed list of (command, image) steps; the model walks it.
  logic [2:0] step_cmd [NSTEP];
  logic       step_img [NSTEP];

  initial begin
    int k;
    k = 0;
    step_cmd[k] = 3'b111; step_img[k] = 1'b0; k++;
    step_cmd[k] = 3'b101; step_img[k] = 1'b0; k++;
    for (int r = 0; r < N; r++) begin
      step_cmd[k] = 3'b000; step_img[k] = 1'b0; k++;
      if (r < N - 1) begin
        step_cmd[k] = 3'b011; step_img[k] = 1'b0; k++;
        step_cmd[k] = 3'b001; step_img[k] = 1'b1; k++;
      end
    end
  end

  bit         m_valid = 0;
  int         m_where;          // 0 idle, 1 issuing, 2 waiting
  int         m_step;
  int         m_waited;
  bit         m_done, m_error;
  int         m_round;
  logic [2:0] m_cmd;
  bit         m_img;
  bit         m_img_known;

  task automatic m_issue(input int s);
    m_where = 1;
    m_step  = s;
    m_cmd   = step_cmd[s];
    m_img   = step_img[s];
    m_img_known = (step_cmd[s] == 3'b011) || (step_cmd[s] == 3'b001);
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      m_valid = 1; m_where = 0; m_step = 0; m_waited = 0;
      m_done = 0; m_error = 0; m_round = 0;
      m_cmd = 3'b111; m_img = 0; m_img_known = 1;
    end else if (!m_valid) begin
      // nothing known before the first reset
    end else if (abort) begin
      m_where = 0;
    end else if (m_where == 0) begin
      if (go) begin
        m_done = 0; m_error = 0; m_round = 0;
        m_issue(0);
      end
    end else if (m_where == 1) begin
      m_where  = 2;
      m_waited = 0;
    end else begin
      if (&pe_ready) begin
        if (step_cmd[m_step] == 3'b001) m_round++;
        if (m_step == NSTEP - 1) begin
          m_where = 0;
          m_done  = 1;
        end else begin
          m_issue(m_step + 1);
        end
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_where = 0;
          m_error = 1;
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    model_edge();
    #1;
    if (m_valid) begin
      chk("ack",   ack,   (m_where == 1) ? 0 : 1);
      chk("start", start, (m_where == 1) ? 1 : 0);
      chk("busy",  busy,  (m_where != 0) ? 1 : 0);
      chk("done",  done,  m_done);
      chk("error", error, m_error);
      chk("round", round, m_round);
      chk("cmd",   command_to_execute, m_cmd);
      if (m_img_known) chk("img", image_to_shift, m_img);
    end
  end

  // ---------------- ready driver ----------------
  int rmode = 0;   // 0 all ready, 1 random, 2 stagger mul, 3 stuck on mul, 4 stuck on round-1 mul
  int wc    = 0;

  always @(negedge clk) begin
    if (start) wc = 0;
    else if (busy) wc++;
    case (rmode)
      1: pe_ready = ($urandom_range(0, 2) == 0) ? '1 : NN'($urandom);
      2: begin
        pe_ready = '1;
        if (command_to_execute == 3'b000 && wc < 7) pe_ready[1] = 1'b0;
      end
      3: begin
        pe_ready = '1;
        if (command_to_execute == 3'b000) pe_ready[0] = 1'b0;
      end
      4: begin
        pe_ready = '1;
        if (command_to_execute == 3'b000 && round == 1) pe_ready[0] = 1'b0;
      end
      default: pe_ready = '1;
    endcase
  end

  // ---------------- issue monitor ----------------
  logic [2:0] issue_log [$];
  logic       img_log   [$];
  int         ack_low = 0;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && start === 1'b1) begin
      issue_log.push_back(command_to_execute);
      img_log.push_back(image_to_shift);
    end
    if (ack === 1'b0) ack_low++;
  end

  task automatic clear_log();
    issue_log.delete();
    img_log.delete();
    ack_low = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Pulse (or hold) go and return the cycle number, counted from the go edge,
  // in which done or error is first seen. extra_go pulses go again in that
  // cycle while the pass is running.
  task automatic go_and_wait(input int extra_go, input bit hold, output int cyc);
    @(negedge clk); go = 1'b1;
    @(posedge clk);
    @(negedge clk); go = hold; cyc = 1;
    while (!(done || error) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      go = hold || (cyc == extra_go);
    end
    if (cyc >= 2000) chk("pass_timeout", 0, 1);
    if (!hold) go = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [2:0] nom_cmds [6];
  logic       nom_imgs [6];

  initial begin
    int cyc;
    int found;
    reset_n = 1'b0; go = 1'b0; abort = 1'b0; pe_ready = '0;
    nom_cmds = '{3'b111, 3'b101, 3'b000, 3'b011, 3'b001, 3'b000};
    nom_imgs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // reset values
    chk("rst_ack",   ack, 1);
    chk("rst_start", start, 0);
    chk("rst_cmd",   command_to_execute, 3'b111);
    chk("rst_img",   image_to_shift, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_error", error, 0);
    chk("rst_round", round, 0);

    // nominal pass, immediate ready
    rmode = 0; clear_log();
    go_and_wait(0, 0, cyc);
    chk("nom_done_cycle", cyc, 13);
    chk("nom_done", done, 1);
    chk("nom_round", round, 1);
    chk("nom_ack_low", ack_low, 6);
    chk("nom_issues", issue_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < issue_log.size()) begin
        chk("nom_cmd_seq", issue_log[i], nom_cmds[i]);
        if (nom_cmds[i] == 3'b011 || nom_cmds[i] == 3'b001)
          chk("nom_img_seq", img_log[i], nom_imgs[i]);
      end
    end
    idle_cycles(3);
    chk("hold_cmd_idle", command_to_execute, 3'b000);

    // go while busy is ignored
    clear_log();
    go_and_wait(5, 0, cyc);
    chk("busy_go_cycle", cyc, 13);
    chk("busy_go_ack_low", ack_low, 6);
    idle_cycles(2);

    // staggered ready on both multiplies: each WAIT lasts 7 cycles
    rmode = 2; clear_log();
    go_and_wait(0, 0, cyc);
    chk("stag_done_cycle", cyc, 25);
    chk("stag_ack_low", ack_low, 6);
    chk("stag_issues", issue_log.size(), 6);
    idle_cycles(2);

    // timeout on the first multiply
    rmode = 3;
    go_and_wait(0, 0, cyc);
    chk("to_cycle", cyc, 22);
    chk("to_error", error, 1);
    chk("to_done", done, 0);
    chk("to_busy", busy, 0);
    idle_cycles(2);
    rmode = 0;
    go_and_wait(0, 0, cyc);
    chk("to_clear_error", error, 0);
    chk("to_clear_done", done, 1);
    idle_cycles(2);

    // abort during round-1 multiply wait
    rmode = 4;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (round == 1 && busy && !start) found = 1;
    end
    chk("abort_reached", found, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 1);
    chk("abort_done", done, 0);
    clear_log();
    idle_cycles(20);
    chk("abort_no_issue", ack_low, 0);
    rmode = 0; clear_log();
    go_and_wait(0, 0, cyc);
    chk("abort_restart_cycle", cyc, 13);
    if (issue_log.size() > 0) chk("abort_restart_cmd", issue_log[0], 3'b111);
    else chk("abort_restart_issued", 0, 1);

    // reset for one cycle mid-pass
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    idle_cycles(5);
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("mrst_ack",   ack, 1);
    chk("mrst_cmd",   command_to_execute, 3'b111);
    chk("mrst_busy",  busy, 0);
    chk("mrst_done",  done, 0);
    chk("mrst_error", error, 0);
    chk("mrst_round", round, 0);
    idle_cycles(2);

    // go held high across completion restarts immediately
    go_and_wait(0, 1, cyc);
    chk("hold_done_cycle", cyc, 13);
    @(negedge clk);
    chk("hold_restart_start", start, 1);
    chk("hold_restart_done", done, 0);
    go = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    chk("hold_second_done", found, 1);

    // randomized traffic
    rmode = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      go      = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      reset_n = ($urandom_range(0, 149) != 0);
    end
    @(negedge clk);
    reset_n = 1'b1; go = 1'b0; abort = 1'b0; rmode = 0;
    idle_cycles(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
